// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller takes the master side: it samples instruction fields and status, and drives every control line.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] ext_sel;
  logic [2:0] alu_op;
  logic       alu_src_b;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pc_src, ir_we, mem_rd, mem_wr, ext_sel, alu_op,
           alu_src_b, reg_we, reg_dst, mem_to_reg, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pc_src, ir_we, mem_rd, mem_wr, ext_sel, alu_op,
           alu_src_b, reg_we, reg_dst, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// datapath controls decoded from the opcode/funct latched in DECODE.
module multicycle_ctrl #(
  parameter bit IGNORE_READY = 1'b0
) (
  input logic             clk,
  input logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    K_RTYPE, K_ADDI, K_ANDI, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILL
  } kind_t;

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    kind_t k;
    k = K_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: k = K_RTYPE;
          default:                           k = K_ILL;
        endcase
      end
      6'h08:   k = K_ADDI;
      6'h0C:   k = K_ANDI;
      6'h0D:   k = K_ORI;
      6'h0F:   k = K_LUI;
      6'h23:   k = K_LW;
      6'h2B:   k = K_SW;
      6'h04:   k = K_BEQ;
      6'h02:   k = K_J;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  kind_t      kind_live, kind_q;
  logic       rdy;

  assign rdy       = IGNORE_READY ? 1'b1 : bus.mem_ready;
  assign kind_live = classify(bus.opcode, bus.funct);
  assign kind_q    = classify(op_q, fn_q);
  assign bus.state = rst ? 3'd0 : state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
    end
  end

  always_comb begin
    state_d        = FETCH;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_we      = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ext_sel    = 2'b01;
    bus.alu_op     = 3'b000;
    bus.alu_src_b  = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;

    // Datapath selects come only from the latched decode so they stay
    // constant from EXEC through WB even if opcode/funct inputs move.
    if (!rst && (state_q == EXEC || state_q == MEM || state_q == WB)) begin
      case (kind_q)
        K_RTYPE: begin
          case (fn_q)
            6'h22:   bus.alu_op = 3'b001;
            6'h24:   bus.alu_op = 3'b010;
            6'h25:   bus.alu_op = 3'b011;
            6'h2A:   bus.alu_op = 3'b100;
            default: bus.alu_op = 3'b000;
          endcase
          bus.reg_dst = 1'b1;
        end
        K_ANDI: begin
          bus.alu_op    = 3'b010;
          bus.ext_sel   = 2'b00;
          bus.alu_src_b = 1'b1;
        end
        K_ORI: begin
          bus.alu_op    = 3'b011;
          bus.ext_sel   = 2'b00;
          bus.alu_src_b = 1'b1;
        end
        K_LUI: begin
          bus.alu_op    = 3'b011;
          bus.ext_sel   = 2'b10;
          bus.alu_src_b = 1'b1;
        end
        K_BEQ:   bus.alu_op = 3'b001;
        K_LW: begin
          bus.alu_src_b  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        default: bus.alu_src_b = 1'b1;
      endcase
    end

    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.mem_rd = 1'b1;
          if (rdy) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
            state_d   = DECODE;
          end else begin
            state_d   = FETCH;
          end
        end
        DECODE: begin
          case (kind_live)
            K_J: begin
              bus.pc_we  = 1'b1;
              bus.pc_src = 2'b10;
              state_d    = FETCH;
            end
            K_ILL: begin
              bus.illegal = 1'b1;
              state_d     = FETCH;
            end
            default: state_d = EXEC;
          endcase
        end
        EXEC: begin
          case (kind_q)
            K_BEQ: begin
              bus.pc_we  = bus.zero;
              bus.pc_src = 2'b01;
              state_d    = FETCH;
            end
            K_LW, K_SW: state_d = MEM;
            default:    state_d = WB;
          endcase
        end
        MEM: begin
          bus.mem_rd = (kind_q == K_LW);
          bus.mem_wr = (kind_q == K_SW);
          if (rdy) state_d = (kind_q == K_LW) ? WB : FETCH;
          else     state_d = MEM;
        end
        WB: begin
          bus.reg_we = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
